fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised synchronous single-clock FIFO. Next generation of the 32x8 FIFO: configurable width and depth, a full-range fill count, programmable almost-full/almost-empty flags, and defined behaviour on full, empty and simultaneous access.
- Sits between producer/consumer datapaths in the same clock domain.
- Storage is a dual-port RAM with registered read.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 32, number of entries; must be a power of 2, >=4.
- AF_LEVEL, DEPTH-4, F_AFULL asserts when count >= AF_LEVEL.
- AE_LEVEL, 4, F_AEMPTY asserts when count <= AE_LEVEL.

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- CLEAR_N  in  1  synchronous active-low flush
- WRITE  in  1  write request
- READ  in  1  read request
- DATA_IN  in  WIDTH  write data
- DATA_OUT  out  WIDTH  read data, registered
- F_FULL_N  out  1  low when count == DEPTH
- F_EMPTY_N  out  1  low when count == 0
- F_AFULL  out  1  almost-full flag
- F_AEMPTY  out  1  almost-empty flag
- USE_DW  out  $clog2(DEPTH)+1  fill count, 0..DEPTH inclusive

Behaviour:
- Reset is RESET_N, asynchronous, active-low; clock is CLOCK. On reset:
  - state=EMPTY, pointers=0, USE_DW=0, DATA_OUT=0.
  - F_EMPTY_N=0, F_FULL_N=1, F_AEMPTY=1, F_AFULL=0.
- CLEAR_N=0 at a clock edge has the same effect as reset, except DATA_OUT holds its value. CLEAR_N has priority over READ and WRITE in that cycle.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Accepted operations:
  - wr_acc = WRITE && (state != FULL || READ)
  - rd_acc = READ && (state != EMPTY)
- Accepted write: mem[wr_ptr] <= DATA_IN, then wr_ptr++.
- Accepted read: DATA_OUT <= mem[rd_ptr] at the same edge (1-cycle read latency), then rd_ptr++. DATA_OUT holds its value when no read is accepted.
- Count update: USE_DW +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. USE_DW never exceeds DEPTH and never underflows.
- Read on EMPTY is ignored: no pointer move, DATA_OUT unchanged. There is no bypass; a simultaneous WRITE+READ on EMPTY performs the write only.
- Write on FULL without READ is ignored.
- Write on FULL with READ: both are performed; the read returns the oldest word, the new word takes the freed slot, and the FIFO stays FULL.
- State machine (registered):
  - EMPTY -> PARTIAL on wr_acc.
  - PARTIAL -> FULL on wr_acc && !rd_acc && USE_DW == DEPTH-1.
  - PARTIAL -> EMPTY on rd_acc && !wr_acc && USE_DW == 1.
  - FULL -> PARTIAL on rd_acc && !wr_acc.
  - All other cases: hold state.
- Flags:
  - F_FULL_N and F_EMPTY_N decode directly from state.
  - F_AFULL and F_AEMPTY are combinational compares of USE_DW against AF_LEVEL and AE_LEVEL.
  - All flags are glitch-free relative to CLOCK because their sources are registered.
- Reset asserted mid-burst discards all contents immediately. The first read after release returns the first word written after release.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, two extra output ports are added: OVERFLOW (1) and UNDERFLOW (1). Both are sticky.
  - OVERFLOW sets on WRITE && !wr_acc.
  - UNDERFLOW sets on READ && !rd_acc.
  - Both clear on RESET_N or CLEAR_N.
- When not defined, the ports do not exist and ignored requests are silently dropped.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t
  - a function to compute the count width from DEPTH.
- One sub-module, fifo_dpram: WIDTH x DEPTH, one write port and one registered read port with read enable, same CLOCK. The FSM, pointers and count stay in the top module.

Test Plan:
- Reset, then READ=1 for 3 cycles -> DATA_OUT=0, USE_DW=0, F_EMPTY_N=0, F_AEMPTY=1; with FIFO_ERR_FLAGS_EN, UNDERFLOW=1.
- Write 32 words 0x00..0x1F (DEPTH=32) -> USE_DW=32 and F_FULL_N=0 after the 32nd write; F_AFULL=1 from USE_DW=28. A 33rd write of 0xAA is ignored and USE_DW stays 32.
- Full FIFO, WRITE+READ with DATA_IN=0x55 -> DATA_OUT=0x00, USE_DW stays 32; after draining 32 reads the last DATA_OUT=0x55, then F_EMPTY_N=0.
- Wrap-around: alternate write/read 70 times with an incrementing pattern -> DATA_OUT always equals the value written one cycle earlier, and USE_DW toggles between 1 and 0.
- Write 10 words, pulse CLEAR_N low for 1 cycle while WRITE=1 -> USE_DW=0 and the write is dropped; the next write 0x3C followed by a read returns 0x3C.
- Write 5 words, assert RESET_N low asynchronously mid-cycle -> all flags and USE_DW return to reset values before the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// The FIFO state encoding and the fill-count width derivation live here so
// the top module and any future siblings agree on them.
package fifo_pkg;

  // Coarse occupancy state; FULL/EMPTY flags decode directly from this.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Fill count must represent 0..DEPTH inclusive, hence one extra bit
  // beyond the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM, WIDTH x DEPTH, one write port and one registered
// read port with read enable, single clock. The read register is
// read-first: a read and a write to the same address in the same cycle
// returns the old word, which the FIFO relies on when full.
// The read register resets to zero so the FIFO output is defined after
// reset; the array itself has no reset so it can map onto block RAM.
module fifo_dpram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // Storage array write port.
  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value unless a read is enabled.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Registered read output.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count and almost-full/almost-empty
// flags. Pointers, fill count and occupancy FSM live here; storage is the
// fifo_dpram sub-module.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky OVERFLOW/UNDERFLOW
// outputs that record ignored write/read requests.
// DEPTH must be a power of two (>= 4) so the pointers wrap naturally.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                        CLOCK,
  input  logic                        RESET_N,
  input  logic                        CLEAR_N,
  input  logic                        WRITE,
  input  logic                        READ,
  input  logic [WIDTH-1:0]            DATA_IN,
  output logic [WIDTH-1:0]            DATA_OUT,
  output logic                        F_FULL_N,
  output logic                        F_EMPTY_N,
  output logic                        F_AFULL,
  output logic                        F_AEMPTY,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                        OVERFLOW,
  output logic                        UNDERFLOW,
`endif
  output logic [cnt_width(DEPTH)-1:0] USE_DW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_NEARLY = CW'(DEPTH - 1);
  localparam logic [CW-1:0] AF_LV      = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_LV      = CW'(AE_LEVEL);

  fifo_state_t   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic wr_acc;
  logic rd_acc;
  logic ram_wr_en;
  logic ram_rd_en;

  // Request acceptance: a write on FULL is only taken when a read frees a
  // slot in the same cycle; a read on EMPTY is never taken (no bypass).
  always_comb begin
    wr_acc    = WRITE && ((state_q != FULL) || READ);
    rd_acc    = READ && (state_q != EMPTY);
    ram_wr_en = wr_acc && CLEAR_N;
    ram_rd_en = rd_acc && CLEAR_N;
  end

  // Next-state, pointer and count logic; flush overrides any access.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (!CLEAR_N) begin
      state_d  = EMPTY;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
      case (state_q)
        EMPTY: begin
          if (wr_acc) begin
            state_d = PARTIAL;
          end
        end
        PARTIAL: begin
          if (wr_acc && !rd_acc && (cnt_q == CNT_NEARLY)) begin
            state_d = FULL;
          end else if (rd_acc && !wr_acc && (cnt_q == CNT_ONE)) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (rd_acc && !wr_acc) begin
            state_d = PARTIAL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  fifo_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (DATA_IN),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (DATA_OUT)
  );

  // Status flags derive only from registered state and count.
  always_comb begin
    F_FULL_N  = (state_q != FULL);
    F_EMPTY_N = (state_q != EMPTY);
    F_AFULL   = (cnt_q >= AF_LV);
    F_AEMPTY  = (cnt_q <= AE_LV);
    USE_DW    = cnt_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags record any request that was dropped.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!CLEAR_N) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (WRITE && !wr_acc) begin
        ovf_d = 1'b1;
      end
      if (READ && !rd_acc) begin
        unf_d = 1'b1;
      end
    end
  end

  // Error flag registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed-vector bench for fifo_sync_param at default parameters
// (WIDTH=8, DEPTH=32, AF_LEVEL=28, AE_LEVEL=4).
module tb_fifo_sync_param;

  logic       CLOCK;
  logic       RESET_N;
  logic       CLEAR_N;
  logic       WRITE;
  logic       READ;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       F_FULL_N;
  logic       F_EMPTY_N;
  logic       F_AFULL;
  logic       F_AEMPTY;
  logic [5:0] USE_DW;
`ifdef FIFO_ERR_FLAGS_EN
  logic       OVERFLOW;
  logic       UNDERFLOW;
`endif

  fifo_sync_param dut (
    .CLOCK     (CLOCK),
    .RESET_N   (RESET_N),
    .CLEAR_N   (CLEAR_N),
    .WRITE     (WRITE),
    .READ      (READ),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .F_FULL_N  (F_FULL_N),
    .F_EMPTY_N (F_EMPTY_N),
    .F_AFULL   (F_AFULL),
    .F_AEMPTY  (F_AEMPTY),
`ifdef FIFO_ERR_FLAGS_EN
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
`endif
    .USE_DW    (USE_DW)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  typedef struct packed {
    logic       clear_n;
    logic       write;
    logic       read;
    logic [7:0] din;
    logic [7:0] dout;
    logic [5:0] cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs [300];
  int   nv;
  int   n_vec;
  int   n_bad;
  logic b_ovf;
  logic b_unf;

  task automatic add(input logic cl, input logic w, input logic r,
                     input logic [7:0] d, input logic [7:0] exp_dout,
                     input int exp_cnt);
    vecs[nv] = '{clear_n: cl, write: w, read: r, din: d, dout: exp_dout,
                 cnt: 6'(exp_cnt), ovf: b_ovf, unf: b_unf};
    nv++;
  endtask

  // Flags are derived from the expected fill count by their definitions.
  task automatic check(input string name, input int idx, input vec_t e);
    logic ef, ee, eaf, eae;
    bit   bad;
    ef  = (e.cnt != 6'd32);
    ee  = (e.cnt != 6'd0);
    eaf = (e.cnt >= 6'd28);
    eae = (e.cnt <= 6'd4);
    bad = (DATA_OUT !== e.dout) || (USE_DW !== e.cnt) || (F_FULL_N !== ef) ||
          (F_EMPTY_N !== ee) || (F_AFULL !== eaf) || (F_AEMPTY !== eae);
`ifdef FIFO_ERR_FLAGS_EN
    if ((OVERFLOW !== e.ovf) || (UNDERFLOW !== e.unf)) begin
      bad = 1'b1;
      $display("FAIL %s[%0d] err flags: got ovf=%b unf=%b, want ovf=%b unf=%b",
               name, idx, OVERFLOW, UNDERFLOW, e.ovf, e.unf);
    end
`endif
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s[%0d]: got dout=%h cnt=%0d full_n=%b empty_n=%b af=%b ae=%b, want dout=%h cnt=%0d full_n=%b empty_n=%b af=%b ae=%b",
               name, idx, DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL, F_AEMPTY,
               e.dout, e.cnt, ef, ee, eaf, eae);
    end else begin
      $display("%s[%0d]: cl=%b w=%b r=%b din=%h -> dout=%h cnt=%0d",
               name, idx, e.clear_n, e.write, e.read, e.din, DATA_OUT, USE_DW);
    end
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] v;
    nv    = 0;
    n_vec = 0;
    n_bad = 0;
    b_ovf = 1'b0;
    b_unf = 1'b0;

    // Reads on empty: ignored, output stays at reset value.
    b_unf = 1'b1;
    for (int i = 0; i < 3; i++) add(1, 0, 1, 8'h00, 8'h00, 0);
    // Fill with 0x00..0x1F.
    for (int i = 0; i < 32; i++) add(1, 1, 0, 8'(i), 8'h00, i + 1);
    // Write on full without read is dropped.
    b_ovf = 1'b1;
    add(1, 1, 0, 8'hAA, 8'h00, 32);
    // Write+read on full: oldest word out, new word takes freed slot.
    add(1, 1, 1, 8'h55, 8'h00, 32);
    // Drain: 0x01..0x1F then 0x55.
    for (int i = 1; i < 32; i++) add(1, 0, 1, 8'h00, 8'(i), 32 - i);
    add(1, 0, 1, 8'h00, 8'h55, 0);
    // Extra read on empty holds output.
    add(1, 0, 1, 8'h00, 8'h55, 0);
    // Write+read on empty performs only the write.
    add(1, 1, 1, 8'h77, 8'h55, 1);
    add(1, 0, 1, 8'h00, 8'h77, 0);
    // Wrap-around: alternate write/read 70 times.
    last = 8'h77;
    for (int k = 0; k < 70; k++) begin
      v = 8'(8'hA0 + k);
      add(1, 1, 0, v, last, 1);
      add(1, 0, 1, 8'h00, v, 0);
      last = v;
    end
    // Ten words then flush with WRITE and READ high: flush wins.
    for (int i = 0; i < 10; i++) add(1, 1, 0, 8'(8'h10 + i), last, i + 1);
    b_ovf = 1'b0;
    b_unf = 1'b0;
    add(0, 1, 1, 8'hEE, last, 0);
    add(1, 1, 0, 8'h3C, last, 1);
    add(1, 0, 1, 8'h00, 8'h3C, 0);

    // Reset state.
    RESET_N = 1'b0;
    CLEAR_N = 1'b1;
    WRITE   = 1'b0;
    READ    = 1'b0;
    DATA_IN = 8'h00;
    repeat (2) @(posedge CLOCK);
    #1;
    check("reset", 0, '{clear_n: 1, write: 0, read: 0, din: 0, dout: 8'h00,
                        cnt: 6'd0, ovf: 0, unf: 0});
    @(negedge CLOCK);
    RESET_N = 1'b1;
    @(posedge CLOCK);
    #1;

    // Table-driven vectors: inputs change 1 time unit after the edge,
    // outputs are checked 1 time unit after the following edge.
    for (int i = 0; i < nv; i++) begin
      CLEAR_N = vecs[i].clear_n;
      WRITE   = vecs[i].write;
      READ    = vecs[i].read;
      DATA_IN = vecs[i].din;
      @(posedge CLOCK);
      #1;
      check("vec", i, vecs[i]);
    end
    CLEAR_N = 1'b1;
    WRITE   = 1'b0;
    READ    = 1'b0;

    // Five writes, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++) begin
      WRITE   = 1'b1;
      DATA_IN = 8'(8'hC0 + i);
      @(posedge CLOCK);
      #1;
      check("prerst", i, '{clear_n: 1, write: 1, read: 0, din: DATA_IN,
                           dout: 8'h3C, cnt: 6'(i + 1), ovf: 0, unf: 0});
    end
    WRITE = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst", 0, '{clear_n: 1, write: 0, read: 0, din: 0, dout: 8'h00,
                            cnt: 6'd0, ovf: 0, unf: 0});
    @(negedge CLOCK);
    RESET_N = 1'b1;
    // First word after release is the first word read back.
    WRITE   = 1'b1;
    DATA_IN = 8'h99;
    @(posedge CLOCK);
    #1;
    check("postrst", 0, '{clear_n: 1, write: 1, read: 0, din: 8'h99, dout: 8'h00,
                          cnt: 6'd1, ovf: 0, unf: 0});
    WRITE = 1'b0;
    READ  = 1'b1;
    @(posedge CLOCK);
    #1;
    check("postrst", 1, '{clear_n: 1, write: 0, read: 1, din: 8'h00, dout: 8'h99,
                          cnt: 6'd0, ovf: 0, unf: 0});
    READ = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
